// File: rtl/e_mdu.sv
// E-stage multiply/divide unit. Runs MULT/MULTU/DIV/DIVU over a fixed busy window
// and owns the architectural HI/LO registers; also serves MTHI/MTLO/MFHI/MFLO.
module e_mdu #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        valid,
   input  logic [3:0]  mdu_op,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        start,
   output logic        busy,
   output logic [31:0] HI,
   output logic [31:0] LO,
   output logic [31:0] rd
);

   localparam int unsigned CNT_W = 4;

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] RUN  = 1'b1;

   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MTHI  = 4'd5;
   localparam logic [3:0] OP_MTLO  = 4'd6;
   localparam logic [3:0] OP_MFHI  = 4'd7;
   localparam logic [3:0] OP_MFLO  = 4'd8;

   logic [0:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      res_hi_q, res_hi_d;
   logic [31:0]      res_lo_q, res_lo_d;
   logic             res_we_q, res_we_d;
   logic [31:0]      hi_q, hi_d;
   logic [31:0]      lo_q, lo_d;

   logic             is_arith;
   logic             is_mult;
   logic [63:0]      mul_s;
   logic [63:0]      mul_u;
   logic [31:0]      a_mag, b_mag, s_den, u_den;
   logic [31:0]      sq_mag, sr_mag, sq, sr, uq, ur;

   assign busy     = (state_q == RUN);
   assign is_arith = (mdu_op >= OP_MULT) && (mdu_op <= OP_DIVU);
   assign is_mult  = (mdu_op == OP_MULT) || (mdu_op == OP_MULTU);
   assign start    = valid && !busy && is_arith;
   assign HI       = hi_q;
   assign LO       = lo_q;

   // Full-width products; low 64 bits of the extended product are exact.
   assign mul_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
   assign mul_u = {32'd0, A} * {32'd0, B};

   // Signed divide on magnitudes so INT_MIN / -1 wraps cleanly; zero divisor guarded.
   always_comb begin
      a_mag  = A[31] ? (32'd0 - A) : A;
      b_mag  = B[31] ? (32'd0 - B) : B;
      s_den  = (b_mag == 32'd0) ? 32'd1 : b_mag;
      u_den  = (B == 32'd0) ? 32'd1 : B;
      sq_mag = a_mag / s_den;
      sr_mag = a_mag % s_den;
      sq     = (A[31] ^ B[31]) ? (32'd0 - sq_mag) : sq_mag;
      sr     = A[31] ? (32'd0 - sr_mag) : sr_mag;
      uq     = A / u_den;
      ur     = A % u_den;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         res_hi_q <= '0;
         res_lo_q <= '0;
         res_we_q <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         res_hi_q <= res_hi_d;
         res_lo_q <= res_lo_d;
         res_we_q <= res_we_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      res_hi_d = res_hi_q;
      res_lo_d = res_lo_q;
      res_we_d = res_we_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d  = RUN;
               cnt_d    = is_mult ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
               res_we_d = is_mult || (B != 32'd0);
               case (mdu_op)
                  OP_MULT:  {res_hi_d, res_lo_d} = mul_s;
                  OP_MULTU: {res_hi_d, res_lo_d} = mul_u;
                  OP_DIV:   {res_hi_d, res_lo_d} = {sr, sq};
                  default:  {res_hi_d, res_lo_d} = {ur, uq};
               endcase
            end else if (valid && mdu_op == OP_MTHI) begin
               hi_d = A;
            end else if (valid && mdu_op == OP_MTLO) begin
               lo_d = A;
            end
         end
         default: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d = IDLE;
               if (res_we_q) begin
                  hi_d = res_hi_q;
                  lo_d = res_lo_q;
               end
            end
         end
      endcase
   end

   // MF* read port; follows mdu_op regardless of valid.
   always_comb begin
      rd = 32'd0;
      if (mdu_op == OP_MFHI)
         rd = hi_q;
      else if (mdu_op == OP_MFLO)
         rd = lo_q;
   end

endmodule

// File: tb/tb_e_mdu.sv
// Self-checking bench for e_mdu: directed corner cases plus randomized ops
// checked against an arithmetic reference of HI/LO and busy duration.
module tb_e_mdu;

   localparam int unsigned MULT_N = 5;
   localparam int unsigned DIV_N  = 10;

   logic        clk = 1'b0;
   logic        reset;
   logic        valid;
   logic [3:0]  mdu_op;
   logic [31:0] A, B;
   logic        start, busy;
   logic [31:0] HI, LO, rd;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] m_hi = 32'd0;
   logic [31:0] m_lo = 32'd0;
   bit          intrude = 1'b0;

   e_mdu #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
      .clk(clk), .reset(reset), .valid(valid), .mdu_op(mdu_op),
      .A(A), .B(B), .start(start), .busy(busy), .HI(HI), .LO(LO), .rd(rd)
   );

   always #5 clk = ~clk;

   // Protocol monitor: MDU-class op offered while busy, outside deliberate probes.
   always @(posedge clk)
      if (!reset && valid && busy && mdu_op >= 4'd1 && mdu_op <= 4'd6 && !intrude)
         $error("protocol violation: op %0d presented while busy", mdu_op);

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Reference: {we, hi, lo} for an arithmetic op.
   function automatic logic [64:0] ref_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, q, r;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (op)
         4'd1: begin p = 64'(sa * sb); return {1'b1, p}; end
         4'd2: begin p = {32'd0, a} * {32'd0, b}; return {1'b1, p}; end
         4'd3: begin
            if (b == 32'd0) return {1'b0, 64'd0};
            q = sa / sb; r = sa % sb;
            return {1'b1, r[31:0], q[31:0]};
         end
         default: begin
            if (b == 32'd0) return {1'b0, 64'd0};
            return {1'b1, a % b, a / b};
         end
      endcase
   endfunction

   task automatic idle_inputs();
      valid = 1'b0; mdu_op = 4'd0; A = $urandom; B = $urandom;
   endtask

   // Called at a negedge; returns at the first negedge with busy low.
   task automatic do_arith(input string tag, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input bit intr);
      logic [64:0] r;
      int          cyc;
      int unsigned n;
      r = ref_op(op, a, b);
      n = (op <= 4'd2) ? MULT_N : DIV_N;
      valid = 1'b1; mdu_op = op; A = a; B = b;
      #1 check({tag, "_start"}, 64'(start), 64'd1);
      @(posedge clk);
      @(negedge clk);
      idle_inputs();
      cyc = 0;
      while (busy && cyc < 40) begin
         cyc++;
         if (intr && cyc == 3) begin
            intrude = 1'b1;
            valid = 1'b1; mdu_op = 4'($urandom_range(1, 6)); A = $urandom; B = $urandom;
            #1 check({tag, "_start_busy"}, 64'(start), 64'd0);
         end
         @(negedge clk);
         if (intrude) begin intrude = 1'b0; idle_inputs(); end
      end
      check({tag, "_busy_cycles"}, 64'(cyc), 64'(n));
      if (r[64]) begin m_hi = r[63:32]; m_lo = r[31:0]; end
      check({tag, "_hi"}, 64'(HI), 64'(m_hi));
      check({tag, "_lo"}, 64'(LO), 64'(m_lo));
   endtask

   task automatic do_mt(input string tag, input logic [3:0] op, input logic [31:0] a);
      valid = 1'b1; mdu_op = op; A = a; B = $urandom;
      #1 check({tag, "_start"}, 64'(start), 64'd0);
      @(posedge clk);
      @(negedge clk);
      idle_inputs();
      if (op == 4'd5) m_hi = a; else m_lo = a;
      check({tag, "_busy"}, 64'(busy), 64'd0);
      check({tag, "_hi"}, 64'(HI), 64'(m_hi));
      check({tag, "_lo"}, 64'(LO), 64'(m_lo));
   endtask

   task automatic do_mf(input string tag, input logic [3:0] op, input logic v);
      valid = v; mdu_op = op;
      #1 check({tag, "_rd"}, 64'(rd), (op == 4'd7) ? 64'(m_hi) : 64'(m_lo));
      @(negedge clk);
      idle_inputs();
   endtask

   initial begin
      logic [3:0]  op;
      logic [31:0] ra, rb;
      reset = 1'b1;
      idle_inputs();
      repeat (2) @(negedge clk);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_hilo", {HI, LO}, 64'd0);
      reset = 1'b0;
      @(negedge clk);

      // Async reset between edges clears state immediately.
      do_mt("pre_rst", 4'd5, 32'hCAFEF00D);
      #2 reset = 1'b1;
      #1 check("async_rst_hi", 64'(HI), 64'd0);
      check("async_rst_busy", 64'(busy), 64'd0);
      m_hi = 32'd0; m_lo = 32'd0;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      do_arith("mult",  4'd1, 32'hFFFFFFFE, 32'd3, 1'b0);
      check("mult_const", {HI, LO}, 64'hFFFFFFFF_FFFFFFFA);
      do_arith("multu", 4'd2, 32'hFFFFFFFE, 32'd3, 1'b0);
      check("multu_const", {HI, LO}, 64'h00000002_FFFFFFFA);
      do_arith("div",   4'd3, 32'hFFFFFFF9, 32'd2, 1'b0);
      check("div_const", {HI, LO}, 64'hFFFFFFFF_FFFFFFFD);
      do_arith("divu",  4'd4, 32'd7, 32'd2, 1'b0);
      check("divu_const", {HI, LO}, 64'h00000001_00000003);
      do_arith("div_ovf", 4'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0);
      check("div_ovf_const", {HI, LO}, 64'h00000000_80000000);

      do_mt("mthi", 4'd5, 32'h12345678);
      do_mt("mtlo", 4'd6, 32'h9ABCDEF0);
      do_arith("div0",  4'd3, 32'h55555555, 32'd0, 1'b0);
      do_arith("divu0", 4'd4, 32'hAAAAAAAA, 32'd0, 1'b0);
      check("div0_const", {HI, LO}, 64'h12345678_9ABCDEF0);
      do_mf("mfhi", 4'd7, 1'b1);
      do_mf("mflo", 4'd8, 1'b1);
      do_mf("mfhi_nv", 4'd7, 1'b0);

      // Reset four cycles into a divide: no late HI/LO update.
      valid = 1'b1; mdu_op = 4'd3; A = 32'd100; B = 32'd7;
      @(posedge clk);
      @(negedge clk);
      idle_inputs();
      repeat (3) @(negedge clk);
      reset = 1'b1;
      #1 check("midrst_busy", 64'(busy), 64'd0);
      m_hi = 32'd0; m_lo = 32'd0;
      @(negedge clk);
      reset = 1'b0;
      repeat (DIV_N + 2) @(negedge clk);
      check("midrst_hilo", {HI, LO}, 64'd0);
      check("midrst_busy_late", 64'(busy), 64'd0);

      // Back-to-back: second op issued on the first idle cycle.
      do_arith("b2b_div",  4'd4, 32'd1000, 32'd33, 1'b0);
      do_arith("b2b_mult", 4'd1, 32'h7FFFFFFF, 32'h80000000, 1'b0);

      // Ops presented while busy must be ignored.
      do_arith("intr_div",  4'd3, 32'hDEADBEEF, 32'd1234, 1'b1);
      do_arith("intr_mult", 4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);

      // valid=0 suppresses start.
      valid = 1'b0; mdu_op = 4'd1; A = 32'd9; B = 32'd9;
      #1 check("nv_start", 64'(start), 64'd0);
      check("nv_rd", 64'(rd), 64'd0);
      @(negedge clk);
      check("nv_busy", 64'(busy), 64'd0);
      check("nv_hilo", {HI, LO}, {m_hi, m_lo});
      idle_inputs();

      for (int i = 0; i < 40; i++) begin
         op = 4'($urandom_range(1, 8));
         ra = $urandom;
         rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
         if ($urandom_range(0, 3) == 0) rb = 32'($signed(rb) >>> 24);
         if (op <= 4'd4)      do_arith($sformatf("rnd%0d_op%0d", i, op), op, ra, rb, ($urandom_range(0, 4) == 0));
         else if (op <= 4'd6) do_mt($sformatf("rnd%0d_mt", i), op, ra);
         else                 do_mf($sformatf("rnd%0d_mf", i), op, 1'b1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule
